// File: rtl/spi_adc_pkg.sv
// Shared state encoding, default frame geometry and counter sizing for the SPI ADC front end.
// Constant and function definitions only; no timing or backpressure behaviour of its own.
package spi_adc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    WRITE  = 2'd2
  } state_e;

  localparam int HALF_DIV_DEF   = 4;
  localparam int FRAME_BITS_DEF = 16;
  localparam int DATA_MSB_DEF   = 11;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: holds sclk high when idle, starts low on start and toggles every HALF_DIV cycles.
// The rise/fall strobes are combinational and flag the edge that moves sclk; stop parks sclk high on that edge.
module spi_sclk_gen
  import spi_adc_pkg::*;
#(
  parameter int HALF_DIV = HALF_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  input  logic stop,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);

  localparam int CW = cnt_width(HALF_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          half_end;

  assign half_end  = (cnt_q == CNT_LAST);
  assign sclk_rise = active && half_end && !sclk_q;
  assign sclk_fall = active && half_end && sclk_q;
  assign sclk      = sclk_q;

  always_comb begin
    sclk_d = 1'b1;
    cnt_d  = '0;
    if (start) begin
      sclk_d = 1'b0;
    end else if (active && !stop) begin
      sclk_d = sclk_q;
      cnt_d  = cnt_q + 1'b1;
      if (half_end) begin
        sclk_d = !sclk_q;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_adc_with_fifo_wr.sv
// SPI ADC front end: one FRAME_BITS read frame per sample request, 8-bit result written to the FIFO; done 2*HALF_DIV*FRAME_BITS+1 cycles after start.
// No backpressure: the FIFO must take one word per frame. SPI_ADC_FRAME_CHECK_EN adds frame_err (nonzero leading bits).
module spi_adc_with_fifo_wr
  import spi_adc_pkg::*;
#(
  parameter int HALF_DIV   = HALF_DIV_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int DATA_MSB   = DATA_MSB_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample,
  input  logic       din1,
  output logic       cs_n,
  output logic       sclk,
  output logic       write_to_fifo,
  output logic       ready,
  output logic       done,
  output logic [7:0] adc1_dout
`ifdef SPI_ADC_FRAME_CHECK_EN
  ,
  output logic       frame_err
`endif
);

  localparam int BCW = cnt_width(FRAME_BITS + 1);
  localparam logic [BCW-1:0] BITS_LAST = BCW'(FRAME_BITS);

  state_e                  state_q, state_d;
  logic                    cs_n_q, cs_n_d;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [FRAME_BITS-1:0]   frame_nxt;
  logic [7:0]              dout_q, dout_d;
  logic                    gen_start, gen_active, gen_stop;
  logic                    sclk_rise, sclk_fall;
`ifdef SPI_ADC_FRAME_CHECK_EN
  logic                    err_q, err_d;
`endif

  spi_sclk_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (reset),
    .start     (gen_start),
    .active    (gen_active),
    .stop      (gen_stop),
    .sclk      (sclk),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  assign gen_active = (state_q == SAMPLE);
  assign frame_nxt  = {shift_q[FRAME_BITS-2:0], din1};

  // bit_cnt counts periods begun (rises); the fall closing period FRAME_BITS is the final capture.
  always_comb begin
    state_d   = state_q;
    cs_n_d    = cs_n_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    dout_d    = dout_q;
    gen_start = 1'b0;
    gen_stop  = 1'b0;
`ifdef SPI_ADC_FRAME_CHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        if (sample) begin
          state_d   = SAMPLE;
          cs_n_d    = 1'b0;
          gen_start = 1'b1;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      SAMPLE: begin
        cs_n_d = 1'b0;
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (sclk_fall) begin
          shift_d = frame_nxt;
          if (bit_cnt_q == BITS_LAST) begin
            state_d  = WRITE;
            cs_n_d   = 1'b1;
            gen_stop = 1'b1;
            dout_d   = frame_nxt[DATA_MSB -: 8];
`ifdef SPI_ADC_FRAME_CHECK_EN
            err_d    = |(frame_nxt >> (DATA_MSB + 1));
`endif
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cs_n_q    <= 1'b1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
`ifdef SPI_ADC_FRAME_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cs_n_q    <= cs_n_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
`ifdef SPI_ADC_FRAME_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign cs_n          = cs_n_q;
  assign ready         = (state_q == IDLE);
  assign done          = (state_q == WRITE);
  assign write_to_fifo = (state_q == WRITE);
  assign adc1_dout     = dout_q;
`ifdef SPI_ADC_FRAME_CHECK_EN
  assign frame_err     = err_q;
`endif

endmodule

// File: tb/tb_spi_adc_with_fifo_wr.sv
// Directed bench for spi_adc_with_fifo_wr at default parameters; the ADC model presents one frame bit per sclk rise.
// Define SPI_ADC_FRAME_CHECK_EN on both bench and RTL to cover frame_err.
module tb_spi_adc_with_fifo_wr;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample;
  logic       din1;
  logic       cs_n;
  logic       sclk;
  logic       write_to_fifo;
  logic       ready;
  logic       done;
  logic [7:0] adc1_dout;
`ifdef SPI_ADC_FRAME_CHECK_EN
  logic       frame_err;
  logic       err_at [2];
`endif

  int         vectors = 0;
  int         miscompares = 0;
  logic [15:0] words [2];
  int         rises [2];
  int         cs_low [2];
  int         done_at [2];
  int         start_at [2];
  logic [7:0] dout_at [2];
  int         done_cycles, wr_cycles, both_cycles, gap_cycles;
  bit         timed_out;

  spi_adc_with_fifo_wr dut (
    .clk           (clk),
    .reset         (reset),
    .sample        (sample),
    .din1          (din1),
    .cs_n          (cs_n),
    .sclk          (sclk),
    .write_to_fifo (write_to_fifo),
    .ready         (ready),
    .done          (done),
    .adc1_dout     (adc1_dout)
`ifdef SPI_ADC_FRAME_CHECK_EN
    ,
    .frame_err     (frame_err)
`endif
  );

  always #5 clk = ~clk;

  // Runs nframes conversions, sampling #1 after each rising edge. Cycle 1 is the one
  // following the edge that accepts sample; done_at is the cycle index where done is seen.
  task automatic drive_frames(input int nframes, input bit hold);
    int   f, cyc, bitn;
    logic prev_sclk;
    bit   in_frame;
    f = 0; cyc = 0; bitn = 0; in_frame = 0; prev_sclk = sclk;
    done_cycles = 0; wr_cycles = 0; both_cycles = 0; gap_cycles = 0; timed_out = 0;
    for (int i = 0; i < 2; i++) begin
      rises[i] = 0; cs_low[i] = 0; done_at[i] = 0; start_at[i] = 0; dout_at[i] = '0;
`ifdef SPI_ADC_FRAME_CHECK_EN
      err_at[i] = 1'b0;
`endif
    end
    sample = 1'b1;
    while (f < nframes) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 400 * nframes) begin
        timed_out = 1;
        break;
      end
      if (write_to_fifo) wr_cycles++;
      if (done) done_cycles++;
      if (done && write_to_fifo) both_cycles++;
      if (!cs_n) begin
        if (!in_frame) begin
          in_frame = 1;
          start_at[f] = cyc;
          if (!hold) sample = 1'b0;
        end
        cs_low[f]++;
        if (sclk && !prev_sclk) begin
          rises[f]++;
          if (bitn < 16) din1 = words[f][15-bitn];
          bitn++;
        end
      end
      if (done) begin
        done_at[f] = cyc - start_at[f] + 1;
        dout_at[f] = adc1_dout;
`ifdef SPI_ADC_FRAME_CHECK_EN
        err_at[f] = frame_err;
`endif
        f++;
        in_frame = 0;
        bitn = 0;
      end
      if (cs_n && f >= 1 && f < nframes) gap_cycles++;
      prev_sclk = sclk;
    end
    sample = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (write_to_fifo) wr_cycles++;
      if (done) done_cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; sample = 1'b0; din1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    vectors++; if (cs_n !== 1'b1) begin miscompares++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
    vectors++; if (sclk !== 1'b1) begin miscompares++; $display("FAIL reset_sclk: got %b want 1", sclk); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (write_to_fifo !== 1'b0) begin miscompares++; $display("FAIL reset_wr: got %b want 0", write_to_fifo); end
    vectors++; if (adc1_dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %h want 00", adc1_dout); end
`ifdef SPI_ADC_FRAME_CHECK_EN
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
`endif
  endtask

  task automatic test_single_frame;
    words[0] = 16'hABCD; words[1] = 16'h0000;
    drive_frames(1, 1'b0);
    vectors++; if (timed_out) begin miscompares++; $display("FAIL single_timeout: no done within budget"); end
    vectors++; if (rises[0] !== 16) begin miscompares++; $display("FAIL single_rises: got %0d want 16", rises[0]); end
    vectors++; if (cs_low[0] !== 128) begin miscompares++; $display("FAIL single_cs_low: got %0d want 128", cs_low[0]); end
    vectors++; if (done_at[0] !== 129) begin miscompares++; $display("FAIL single_done_cycle: got %0d want 129", done_at[0]); end
    vectors++; if (done_cycles !== 1) begin miscompares++; $display("FAIL single_done_width: got %0d want 1", done_cycles); end
    vectors++; if (wr_cycles !== 1) begin miscompares++; $display("FAIL single_wr_width: got %0d want 1", wr_cycles); end
    vectors++; if (both_cycles !== 1) begin miscompares++; $display("FAIL single_done_wr_same: got %0d want 1", both_cycles); end
    vectors++; if (dout_at[0] !== 8'hBC) begin miscompares++; $display("FAIL single_dout: got %h want bc", dout_at[0]); end
    vectors++; if (adc1_dout !== 8'hBC) begin miscompares++; $display("FAIL single_dout_hold: got %h want bc", adc1_dout); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL single_ready_after: got %b want 1", ready); end
`ifdef SPI_ADC_FRAME_CHECK_EN
    vectors++; if (err_at[0] !== 1'b1) begin miscompares++; $display("FAIL single_frame_err: got %b want 1", err_at[0]); end
    vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL single_frame_err_hold: got %b want 1", frame_err); end
`endif
  endtask

  task automatic test_back_to_back;
    words[0] = 16'hABCD; words[1] = 16'h0FF0;
    drive_frames(2, 1'b1);
    vectors++; if (timed_out) begin miscompares++; $display("FAIL b2b_timeout: frames did not complete"); end
    vectors++; if (dout_at[0] !== 8'hBC) begin miscompares++; $display("FAIL b2b_dout0: got %h want bc", dout_at[0]); end
    vectors++; if (dout_at[1] !== 8'hFF) begin miscompares++; $display("FAIL b2b_dout1: got %h want ff", dout_at[1]); end
    vectors++; if (gap_cycles !== 2) begin miscompares++; $display("FAIL b2b_gap: got %0d want 2", gap_cycles); end
    vectors++; if (done_cycles !== 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 2", done_cycles); end
    vectors++; if (rises[1] !== 16) begin miscompares++; $display("FAIL b2b_rises1: got %0d want 16", rises[1]); end
    vectors++; if (cs_low[1] !== 128) begin miscompares++; $display("FAIL b2b_cs_low1: got %0d want 128", cs_low[1]); end
  endtask

  task automatic test_reset_abort;
    int n;
    bit started;
    started = 0;
    din1 = 1'b1;
    sample = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!cs_n) begin started = 1; break; end
    end
    sample = 1'b0;
    vectors++; if (!started) begin miscompares++; $display("FAIL abort_start: cs_n never fell"); end
    // 64 further edges put the frame just past its 8th capture
    repeat (64) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++; if (cs_n !== 1'b1) begin miscompares++; $display("FAIL abort_cs_n: got %b want 1", cs_n); end
    vectors++; if (sclk !== 1'b1) begin miscompares++; $display("FAIL abort_sclk: got %b want 1", sclk); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %b want 1", ready); end
    vectors++; if (adc1_dout !== 8'h00) begin miscompares++; $display("FAIL abort_dout: got %h want 00", adc1_dout); end
    vectors++; if (done !== 1'b0 || write_to_fifo !== 1'b0) begin
      miscompares++; $display("FAIL abort_strobes: got done=%b wr=%b want 0/0", done, write_to_fifo);
    end
    @(negedge clk); reset = 1'b0;
    n = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || write_to_fifo) n++;
    end
    vectors++; if (n !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d strobe cycles want 0", n); end
    words[0] = 16'h0120; words[1] = 16'h0000;
    drive_frames(1, 1'b0);
    vectors++; if (timed_out) begin miscompares++; $display("FAIL abort_next_timeout: no done within budget"); end
    vectors++; if (dout_at[0] !== 8'h12) begin miscompares++; $display("FAIL abort_next_dout: got %h want 12", dout_at[0]); end
    vectors++; if (done_at[0] !== 129) begin miscompares++; $display("FAIL abort_next_done_cycle: got %0d want 129", done_at[0]); end
`ifdef SPI_ADC_FRAME_CHECK_EN
    vectors++; if (err_at[0] !== 1'b0) begin miscompares++; $display("FAIL abort_next_frame_err: got %b want 0", err_at[0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
